// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and UART-side signals for uart_tx_arbiter.
// slave = the arbiter; master = whatever drives requests and owns the UART FIFO.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               wr_uart;
    logic [7:0]         tx_data;
    logic               tx_full;
    logic [2:0]         grant_id;
    logic               busy;
    logic               trunc_err;

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, wr_uart, tx_data, grant_id, busy, trunc_err
    );

    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, wr_uart, tx_data, grant_id, busy, trunc_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX write port among
// N_REQ byte-stream requesters, with an optional one-byte source header.
module uart_tx_arbiter #(
    parameter int         N_REQ    = 4,
    parameter bit         HDR_EN   = 1'b1,
    parameter logic [7:0] HDR_BASE = 8'hA0,
    parameter int         MAX_LEN  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t     state_reg;
    logic [2:0] grant_reg;
    logic [2:0] last_grant_reg;
    logic [7:0] count_reg;

    // Requester inputs padded to 8 lanes so a 3-bit grant index always fits.
    logic [7:0] valid8;
    logic [7:0] last8;
    logic [7:0] data_arr [8];
    logic [7:0] ready8;

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        if (gi < N_REQ) begin : g_used
            assign valid8[gi]   = bus.req_valid[gi];
            assign last8[gi]    = bus.req_last[gi];
            assign data_arr[gi] = bus.req_data[8*gi +: 8];
        end else begin : g_unused
            assign valid8[gi]   = 1'b0;
            assign last8[gi]    = 1'b0;
            assign data_arr[gi] = 8'h00;
        end
    end

    // Rotating priority search starting just after the previous winner.
    logic       pick_found;
    logic [2:0] pick_idx;
    logic [2:0] cand;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        cand       = (last_grant_reg == 3'(N_REQ - 1)) ? 3'd0 : last_grant_reg + 3'd1;
        for (int k = 0; k < N_REQ; k++) begin
            if (!pick_found && valid8[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
            cand = (cand == 3'(N_REQ - 1)) ? 3'd0 : cand + 3'd1;
        end
    end

    logic       g_valid;
    logic       g_last;
    logic [7:0] g_data;
    logic [7:0] count_inc;
    logic       at_max;

    assign g_valid   = valid8[grant_reg];
    assign g_last    = last8[grant_reg];
    assign g_data    = data_arr[grant_reg];
    assign count_inc = count_reg + 8'd1;
    assign at_max    = (count_inc == 8'(MAX_LEN));

    logic       wr_c;
    logic [7:0] data_c;
    logic       trunc_c;
    logic       accept;
    logic       pkt_end;

    always_comb begin
        ready8  = 8'h00;
        wr_c    = 1'b0;
        data_c  = 8'h00;
        trunc_c = 1'b0;
        accept  = 1'b0;
        pkt_end = 1'b0;
        case (state_reg)
            HDR: begin
                wr_c = !bus.tx_full;
                if (!bus.tx_full)
                    data_c = HDR_BASE | {5'd0, grant_reg};
            end
            DATA: begin
                ready8[grant_reg] = !bus.tx_full;
                accept  = g_valid && !bus.tx_full;
                wr_c    = accept;
                if (accept)
                    data_c = g_data;
                pkt_end = accept && (g_last || at_max);
                trunc_c = accept && at_max && !g_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            grant_reg      <= 3'd0;
            last_grant_reg <= 3'(N_REQ - 1);
            count_reg      <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        grant_reg <= pick_idx;
                        count_reg <= 8'd0;
                        state_reg <= HDR_EN ? HDR : DATA;
                    end
                end
                HDR: begin
                    if (!bus.tx_full)
                        state_reg <= DATA;
                end
                DATA: begin
                    if (accept)
                        count_reg <= count_inc;
                    // Truncated packets release the port; the rest re-arbitrates later.
                    if (pkt_end) begin
                        last_grant_reg <= grant_reg;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready8[N_REQ-1:0];
    assign bus.wr_uart   = wr_c;
    assign bus.tx_data   = data_c;
    assign bus.trunc_err = trunc_c;
    assign bus.grant_id  = grant_reg;
    assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with headers and MAX_LEN=4,
// one without headers; each cycle's outputs are logged and checked per scenario.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(4)) bus_h ();
    uart_tx_arbiter_if #(.N_REQ(4)) bus_n ();

    uart_tx_arbiter #(.N_REQ(4), .HDR_EN(1'b1), .HDR_BASE(8'hA0), .MAX_LEN(4)) dut_h (
        .clk(clk), .rst_n(rst_n), .bus(bus_h)
    );
    uart_tx_arbiter #(.N_REQ(4), .HDR_EN(1'b0), .HDR_BASE(8'hA0), .MAX_LEN(16)) dut_n (
        .clk(clk), .rst_n(rst_n), .bus(bus_n)
    );

    logic [3:0]  rv [2];
    logic [3:0]  rl [2];
    logic [31:0] rd [2];
    logic        tf [2];
    logic        txf [2];
    logic [3:0]  en [2];

    assign bus_h.req_valid = rv[0];
    assign bus_h.req_last  = rl[0];
    assign bus_h.req_data  = rd[0];
    assign bus_h.tx_full   = tf[0];
    assign bus_n.req_valid = rv[1];
    assign bus_n.req_last  = rl[1];
    assign bus_n.req_data  = rd[1];
    assign bus_n.tx_full   = tf[1];

    typedef struct packed {
        logic       wr;
        logic [7:0] data;
        logic       busy;
        logic [3:0] ready;
        logic       trunc;
        logic [2:0] gid;
    } obs_t;

    logic [8:0] src_q [8][$];
    obs_t       log_q [2][$];

    int errors = 0;
    int checks = 0;

    task automatic clear_all();
        for (int k = 0; k < 8; k++) src_q[k].delete();
        for (int d = 0; d < 2; d++) begin
            rv[d] = '0; rl[d] = '0; rd[d] = '0;
            tf[d] = 1'b0; txf[d] = 1'b0; en[d] = 4'hF;
            log_q[d].delete();
        end
    endtask

    task automatic tick();
        obs_t       o;
        logic [3:0] fire [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tf[d] = txf[d];
            for (int i = 0; i < 4; i++) begin
                if (en[d][i] && src_q[d*4+i].size() > 0) begin
                    rv[d][i]       = 1'b1;
                    rl[d][i]       = src_q[d*4+i][0][8];
                    rd[d][8*i +: 8] = src_q[d*4+i][0][7:0];
                end else begin
                    rv[d][i]       = 1'b0;
                    rl[d][i]       = 1'b0;
                    rd[d][8*i +: 8] = 8'h00;
                end
            end
        end
        #1;
        o = '{bus_h.wr_uart, bus_h.tx_data, bus_h.busy, bus_h.req_ready, bus_h.trunc_err, bus_h.grant_id};
        log_q[0].push_back(o);
        o = '{bus_n.wr_uart, bus_n.tx_data, bus_n.busy, bus_n.req_ready, bus_n.trunc_err, bus_n.grant_id};
        log_q[1].push_back(o);
        fire[0] = rv[0] & bus_h.req_ready;
        fire[1] = rv[1] & bus_n.req_ready;
        @(posedge clk);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++)
                if (fire[d][i]) void'(src_q[d*4+i].pop_front());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_all();
        #3;
        checks++; if (bus_h.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_h.busy); end
        checks++; if (bus_h.wr_uart !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b expected 0", bus_h.wr_uart); end
        checks++; if (bus_h.req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %h expected 0", bus_h.req_ready); end
        checks++; if (bus_h.tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus_h.tx_data); end
        checks++; if (bus_h.grant_id !== 3'd0) begin errors++; $display("FAIL reset_gid: got %0d expected 0", bus_h.grant_id); end
        checks++; if (bus_h.trunc_err !== 1'b0) begin errors++; $display("FAIL reset_trunc: got %b expected 0", bus_h.trunc_err); end
        checks++; if (bus_n.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_n: got %b expected 0", bus_n.busy); end
    endtask

    task automatic test_single();
        logic [7:0] eb [4] = '{8'hA2, 8'h11, 8'h22, 8'h33};
        int         ec [4] = '{1, 2, 3, 4};
        int         n = 0;
        int         nt = 0;
        do_reset();
        src_q[2] = '{9'h011, 9'h022, 9'h133};
        repeat (8) tick();
        for (int c = 0; c < log_q[0].size(); c++) begin
            if (log_q[0][c].trunc) nt++;
            if (log_q[0][c].wr) begin
                if (n < 4) begin
                    checks++;
                    if (log_q[0][c].data !== eb[n] || c != ec[n]) begin
                        errors++; $display("FAIL single_byte%0d: got %h@%0d expected %h@%0d", n, log_q[0][c].data, c, eb[n], ec[n]);
                    end
                end
                n++;
            end
        end
        checks++; if (n != 4) begin errors++; $display("FAIL single_count: got %0d expected 4", n); end
        checks++; if (log_q[0][0].busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b expected 0", log_q[0][0].busy); end
        checks++; if (log_q[0][4].busy !== 1'b1) begin errors++; $display("FAIL single_busy_last: got %b expected 1", log_q[0][4].busy); end
        checks++; if (log_q[0][5].busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", log_q[0][5].busy); end
        checks++; if (log_q[0][1].gid !== 3'd2) begin errors++; $display("FAIL single_gid: got %0d expected 2", log_q[0][1].gid); end
        checks++; if (nt != 0) begin errors++; $display("FAIL single_trunc: got %0d expected 0", nt); end
    endtask

    task automatic test_round_robin();
        logic [7:0] eb [12] = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h11, 8'h12,
                                8'hA3, 8'h31, 8'h32, 8'hA0, 8'h03, 8'h04};
        int         ec [12] = '{1, 2, 3, 5, 6, 7, 9, 10, 11, 13, 14, 15};
        int         n = 0;
        do_reset();
        src_q[0] = '{9'h001, 9'h102, 9'h003, 9'h104};
        src_q[1] = '{9'h011, 9'h112};
        src_q[3] = '{9'h031, 9'h132};
        repeat (18) tick();
        for (int c = 0; c < log_q[0].size(); c++) begin
            if (log_q[0][c].wr) begin
                if (n < 12) begin
                    checks++;
                    if (log_q[0][c].data !== eb[n] || c != ec[n]) begin
                        errors++; $display("FAIL rr_byte%0d: got %h@%0d expected %h@%0d", n, log_q[0][c].data, c, eb[n], ec[n]);
                    end
                end
                n++;
            end
        end
        checks++; if (n != 12) begin errors++; $display("FAIL rr_count: got %0d expected 12", n); end
        for (int c = 4; c <= 12; c += 4) begin
            checks++;
            if (log_q[0][c].busy !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: busy got %b expected 0", c, log_q[0][c].busy); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] eb [4] = '{8'hA1, 8'h55, 8'h66, 8'h77};
        int         ec [4] = '{1, 2, 8, 9};
        int         n = 0;
        do_reset();
        src_q[1] = '{9'h055, 9'h066, 9'h177};
        for (int c = 0; c < 12; c++) begin
            txf[0] = (c >= 3 && c <= 7);
            tick();
        end
        for (int c = 3; c <= 7; c++) begin
            checks++;
            if (log_q[0][c].wr !== 1'b0 || log_q[0][c].ready !== 4'h0) begin
                errors++; $display("FAIL bp_stall%0d: wr=%b ready=%h expected wr=0 ready=0", c, log_q[0][c].wr, log_q[0][c].ready);
            end
        end
        for (int c = 0; c < log_q[0].size(); c++) begin
            if (log_q[0][c].wr) begin
                if (n < 4) begin
                    checks++;
                    if (log_q[0][c].data !== eb[n] || c != ec[n]) begin
                        errors++; $display("FAIL bp_byte%0d: got %h@%0d expected %h@%0d", n, log_q[0][c].data, c, eb[n], ec[n]);
                    end
                end
                n++;
            end
        end
        checks++; if (n != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", n); end
    endtask

    task automatic test_truncation();
        logic [7:0] eb [8] = '{8'hA1, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA1, 8'h05, 8'h06};
        int         ec [8] = '{1, 2, 3, 4, 5, 7, 8, 9};
        int         n = 0;
        int         nt = 0;
        do_reset();
        src_q[1] = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h106};
        repeat (12) tick();
        for (int c = 0; c < log_q[0].size(); c++) begin
            if (log_q[0][c].trunc) begin
                nt++;
                checks++;
                if (c != 5) begin errors++; $display("FAIL trunc_cycle: got %0d expected 5", c); end
            end
            if (log_q[0][c].wr) begin
                if (n < 8) begin
                    checks++;
                    if (log_q[0][c].data !== eb[n] || c != ec[n]) begin
                        errors++; $display("FAIL trunc_byte%0d: got %h@%0d expected %h@%0d", n, log_q[0][c].data, c, eb[n], ec[n]);
                    end
                end
                n++;
            end
        end
        checks++; if (n != 8) begin errors++; $display("FAIL trunc_count: got %0d expected 8", n); end
        checks++; if (nt != 1) begin errors++; $display("FAIL trunc_pulses: got %0d expected 1", nt); end
    endtask

    task automatic test_stall_nohdr();
        logic [7:0] eb [5] = '{8'h01, 8'h02, 8'h03, 8'h11, 8'h12};
        int         ec [5] = '{1, 12, 13, 15, 16};
        int         n = 0;
        do_reset();
        src_q[4] = '{9'h001, 9'h002, 9'h103};
        src_q[5] = '{9'h011, 9'h112};
        for (int c = 0; c < 20; c++) begin
            en[1][0] = !(c >= 2 && c <= 11);
            tick();
        end
        for (int c = 0; c < log_q[1].size(); c++) begin
            if (log_q[1][c].wr) begin
                if (n < 5) begin
                    checks++;
                    if (log_q[1][c].data !== eb[n] || c != ec[n]) begin
                        errors++; $display("FAIL stall_byte%0d: got %h@%0d expected %h@%0d", n, log_q[1][c].data, c, eb[n], ec[n]);
                    end
                end
                n++;
            end
        end
        checks++; if (n != 5) begin errors++; $display("FAIL stall_count: got %0d expected 5", n); end
        checks++;
        if (log_q[1][6].busy !== 1'b1 || log_q[1][6].gid !== 3'd0) begin
            errors++; $display("FAIL stall_hold: busy=%b gid=%0d expected busy=1 gid=0", log_q[1][6].busy, log_q[1][6].gid);
        end
        checks++; if (log_q[1][15].gid !== 3'd1) begin errors++; $display("FAIL stall_gid2: got %0d expected 1", log_q[1][15].gid); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] eb [5] = '{8'hA0, 8'h01, 8'hA2, 8'h22, 8'h23};
        int         ec [5] = '{1, 2, 4, 5, 6};
        int         n = 0;
        do_reset();
        src_q[2] = '{9'h021, 9'h022, 9'h123};
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus_h.busy !== 1'b0 || bus_h.wr_uart !== 1'b0 || bus_h.req_ready !== 4'h0 ||
            bus_h.tx_data !== 8'h00 || bus_h.grant_id !== 3'd0 || bus_h.trunc_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%b wr=%b ready=%h data=%h gid=%0d trunc=%b expected all zero",
                     bus_h.busy, bus_h.wr_uart, bus_h.req_ready, bus_h.tx_data, bus_h.grant_id, bus_h.trunc_err);
        end
        #1 rst_n = 1'b1;
        log_q[0].delete();
        src_q[2] = '{9'h022, 9'h123};
        src_q[0] = '{9'h101};
        repeat (8) tick();
        for (int c = 0; c < log_q[0].size(); c++) begin
            if (log_q[0][c].wr) begin
                if (n < 5) begin
                    checks++;
                    if (log_q[0][c].data !== eb[n] || c != ec[n]) begin
                        errors++; $display("FAIL mid_byte%0d: got %h@%0d expected %h@%0d", n, log_q[0][c].data, c, eb[n], ec[n]);
                    end
                end
                n++;
            end
        end
        checks++; if (n != 5) begin errors++; $display("FAIL mid_count: got %0d expected 5", n); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_truncation();
        test_stall_nohdr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
